// File: rtl/i2s_recv.sv
// i2s_recv: I2S receiver that resynchronizes sclk/ws/sd into Clk and delivers {left,right} frames.
// Rev 1.0
`default_nettype none

module i2s_recv #(
  parameter int SIZE = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            sclk,
  input  logic            ws,
  input  logic            sd,
  input  logic            ready,
  output logic [SIZE-1:0] data_left,
  output logic [SIZE-1:0] data_right,
  output logic            valid,
  output logic            overrun
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            sclk_s1, sclk_s2, sclk_s3;
  logic            ws_s1, ws_s2, sd_s1, sd_s2;
  logic            ws_d;
  logic [CW-1:0]   bit_cnt;
  logic [SIZE-1:0] shift, hold, word;
  logic [SIZE-1:0] frame_l, frame_r;
  logic            frame_stb;
  logic            rise, boundary;
  logic            capture, commit_left, commit_right;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ws_s1   <= 1'b0;
      ws_s2   <= 1'b0;
      sd_s1   <= 1'b0;
      sd_s2   <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ws_s1   <= ws;
      ws_s2   <= ws_s1;
      sd_s1   <= sd;
      sd_s2   <= sd_s1;
    end
  end

  assign rise     = sclk_s2 & ~sclk_s3;
  assign boundary = (ws_s2 != ws_d);

  // Current word with this rise's bit dropped into its MSB-first slot; bits past SIZE fall away.
  always_comb begin
    word = shift;
    for (int i = 0; i < SIZE; i++) begin
      if (bit_cnt == CW'(SIZE - 1 - i)) word[i] = sd_s2;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    commit_left  = 1'b0;
    commit_right = 1'b0;
    case (state)
      SYNC: begin
        if (rise && boundary && !ws_s2) state_next = LEFT;
      end
      LEFT: begin
        if (rise) begin
          capture = 1'b1;
          if (boundary) begin
            commit_left = 1'b1;
            state_next  = RIGHT;
          end
        end
      end
      RIGHT: begin
        if (rise) begin
          capture = 1'b1;
          if (boundary) begin
            commit_right = 1'b1;
            state_next   = LEFT;
          end
        end
      end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ws_d      <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      hold      <= '0;
      frame_l   <= '0;
      frame_r   <= '0;
      frame_stb <= 1'b0;
    end else begin
      if (rise) ws_d <= ws_s2;
      if (commit_left || commit_right) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (capture) begin
        shift <= word;
        if (bit_cnt != CW'(SIZE)) bit_cnt <= bit_cnt + CW'(1);
      end
      if (commit_left) hold <= word;
      frame_stb <= commit_right;
      if (commit_right) begin
        frame_l <= hold;
        frame_r <= word;
      end
    end
  end

  // A frame arriving while the previous one is still unaccepted is dropped and flagged.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_left  <= '0;
      data_right <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (frame_stb) begin
        if (!valid || ready) begin
          data_left  <= frame_l;
          data_right <= frame_r;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_recv.sv
// tb_i2s_recv: vector table, corner sequences and randomized frames for i2s_recv.
`default_nettype none

module tb_i2s_recv;

  localparam int SIZE = 16;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            sclk = 1'b0;
  logic            ws = 1'b0;
  logic            sd = 1'b0;
  logic            ready = 1'b1;
  logic [SIZE-1:0] data_left, data_right;
  logic            valid, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int half_ns  = 160;

  int              n_deliv = 0;
  logic [SIZE-1:0] got_l = '0, got_r = '0;
  logic            prev_valid = 1'b0, prev_ready = 1'b0;

  i2s_recv #(.SIZE(SIZE)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .sclk       (sclk),
    .ws         (ws),
    .sd         (sd),
    .ready      (ready),
    .data_left  (data_left),
    .data_right (data_right),
    .valid      (valid),
    .overrun    (overrun)
  );

  always #10 Clk = ~Clk;

  // A delivery is valid appearing fresh, or staying high after the consumer took the last one.
  always @(negedge Clk) begin
    if (valid && (!prev_valid || prev_ready)) begin
      n_deliv++;
      got_l = data_left;
      got_r = data_right;
    end
    prev_valid = valid;
    prev_ready = ready;
  end

  typedef struct {
    logic [31:0] l;
    int          ln;
    logic [31:0] r;
    int          rn;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter drives ws/sd with sclk low; the receiver samples at the rising edge.
  task automatic send_bit(input logic w, input logic b);
    sclk = 1'b0;
    ws   = w;
    sd   = b;
    #(half_ns);
    sclk = 1'b1;
    #(half_ns);
  endtask

  // ws flips on the final bit, which is how I2S marks a word's LSB.
  task automatic send_word(input logic ch, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? ~ch : ch, v[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input int ln, input logic [31:0] r, input int rn);
    send_word(1'b0, l, ln);
    send_word(1'b1, r, rn);
  endtask

  task automatic settle();
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic frame_test(input string name, input logic [31:0] l, input int ln,
                            input logic [31:0] r, input int rn,
                            input logic [15:0] el, input logic [15:0] er);
    int d0;
    d0 = n_deliv;
    send_frame(l, ln, r, rn);
    settle();
    check({name, "_count"}, 32'(n_deliv - d0), 32'd1);
    check({name, "_left"}, 32'(got_l), 32'(el));
    check({name, "_right"}, 32'(got_r), 32'(er));
  endtask

  function automatic logic [15:0] model(input logic [31:0] v, input int n);
    if (n >= SIZE) return 16'(v >> (n - SIZE));
    else           return 16'(v << (SIZE - n));
  endfunction

  function automatic logic [31:0] mask(input int n);
    logic [31:0] one;
    one = 32'd1;
    if (n >= 32) return '1;
    return (one << n) - one;
  endfunction

  task automatic check_zero_outputs(input string name);
    check({name, "_dl"}, 32'(data_left), 32'd0);
    check({name, "_dr"}, 32'(data_right), 32'd0);
    check({name, "_valid"}, 32'(valid), 32'd0);
    check({name, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge Clk);
    #3;
    Reset_n = 1'b1;
  endtask

  initial begin
    #50ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int ln, rn;
    logic [31:0] l, r;

    vecs[0] = '{32'h0000A5C3, 16, 32'h00001234, 16, 16'hA5C3, 16'h1234};
    vecs[1] = '{32'h000000AB,  8, 32'h0000FFFF, 16, 16'hAB00, 16'hFFFF};
    vecs[2] = '{32'h00012345, 20, 32'h000FEDCB, 20, 16'h1234, 16'hFEDC};
    vecs[3] = '{32'h00000001,  1, 32'h00000003,  2, 16'h8000, 16'hC000};
    vecs[4] = '{32'h000FFFFF, 20, 32'h00000000, 16, 16'hFFFF, 16'h0000};
    vecs[5] = '{32'h00008001, 16, 32'h00007FFE, 15, 16'h8001, 16'hFFFC};
    vecs[6] = '{32'h00ABCDEF, 24, 32'h0001FFFF, 17, 16'hABCD, 16'hFFFF};

    #3;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge Clk);
    #3;
    Reset_n = 1'b1;

    // Sync frame: its right word's end is the first ws 1->0 boundary.
    send_word(1'b1, 32'h0000BEEF, 16);
    settle();
    check("sync_no_valid", 32'(n_deliv), 32'd0);

    for (int i = 0; i < 7; i++) begin
      frame_test($sformatf("vec%0d", i), vecs[i].l, vecs[i].ln, vecs[i].r, vecs[i].rn,
                 vecs[i].el, vecs[i].er);
    end
    check("table_overrun", 32'(overrun), 32'd0);

    // Back-pressure: the second frame is dropped and overrun latches.
    @(posedge Clk);
    #2;
    ready = 1'b0;
    d0 = n_deliv;
    send_frame(32'h1111, 16, 32'h2222, 16);
    send_frame(32'h3333, 16, 32'h4444, 16);
    settle();
    check("bp_count", 32'(n_deliv - d0), 32'd1);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_left", 32'(data_left), 32'h1111);
    check("bp_right", 32'(data_right), 32'h2222);
    check("bp_overrun", 32'(overrun), 32'd1);
    @(posedge Clk);
    #2;
    ready = 1'b1;
    @(posedge Clk);
    #1;
    check("bp_valid_clear", 32'(valid), 32'd0);
    check("bp_overrun_sticky", 32'(overrun), 32'd1);

    // Reset after 5 bits of a left word; resume only after the next 1->0 boundary.
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    #5;
    pulse_reset();
    d0 = n_deliv;
    send_word(1'b0, 32'h000007FF, 11);
    send_word(1'b1, 32'h0000FFFF, 16);
    settle();
    check("rst_partial_no_valid", 32'(n_deliv - d0), 32'd0);
    frame_test("rst_resume", 32'hCAFE, 16, 32'hBEEF, 16, 16'hCAFE, 16'hBEEF);

    // Stream joined mid-word: the fragments before the first 1->0 boundary are ignored.
    pulse_reset();
    d0 = n_deliv;
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1);
    send_word(1'b1, 32'h15, 5);
    settle();
    check("midword_no_valid", 32'(n_deliv - d0), 32'd0);
    frame_test("midword_next", 32'h0F0F, 16, 32'hF0F0, 16, 16'h0F0F, 16'hF0F0);

    for (int k = 0; k < 12; k++) begin
      half_ns = 20 * $urandom_range(4, 8);
      ln = $urandom_range(8, 24);
      rn = $urandom_range(8, 24);
      l  = $urandom & mask(ln);
      r  = $urandom & mask(rn);
      frame_test($sformatf("rand%0d", k), l, ln, r, rn, model(l, ln), model(r, rn));
    end
    check("rand_overrun", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_recv.md
I2S_RECV -- requirements
Module: i2s_recv

Interface
REQ-001 SHALL have parameter SIZE, default 16: captured bits per channel word, allowed range 8..32.
REQ-002 Clk  input  1  system clock, 50 MHz; all internal state on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset; one clock only.
REQ-004 sclk  input  1  I2S bit clock, asynchronous to Clk.
REQ-005 ws  input  1  I2S word select: 0 = left channel, 1 = right channel.
REQ-006 sd  input  1  I2S serial data, MSB first.
REQ-007 ready  input  1  consumer accepts frame when high.
REQ-008 data_left  output  SIZE  last delivered left word.
REQ-009 data_right  output  SIZE  last delivered right word.
REQ-010 valid  output  1  frame available on data_left/data_right.
REQ-011 overrun  output  1  sticky: frame dropped because the previous frame was not accepted.

Function
REQ-012 SHALL pass sclk, ws and sd each through an identical 2-flop synchronizer; a third sclk flop SHALL detect rise = sync2 & ~sync3.
REQ-013 SHALL require sclk high and low phases of at least 3 Clk cycles each; behaviour at faster sclk is undefined.
REQ-014 SHALL act only on rise cycles; sclk falling edges SHALL be ignored.
REQ-015 SHALL hold ws_d, the synchronized ws from the previous rise; the sd bit sampled at a rise belongs to channel ws_d.
REQ-016 At a rise where synchronized ws differs from ws_d, the bit sampled SHALL be the last bit of the current word; the word SHALL then be committed and the bit counter cleared.
REQ-017 The first SIZE bits of a word SHALL be kept MSB-first; bits beyond SIZE SHALL be discarded.
REQ-018 A word shorter than SIZE SHALL be zero-padded in its LSBs at commit.
REQ-019 The bit counter SHALL saturate at SIZE; it SHALL not wrap.
REQ-020 States SHALL be SYNC, LEFT and RIGHT; reset enters SYNC.
REQ-021 SYNC: no capture. A ws 1->0 boundary SHALL move to LEFT, with the first captured bit at the next rise.
REQ-022 LEFT: a commit SHALL store the left word in a holding register and move to RIGHT.
REQ-023 RIGHT: a commit SHALL form the frame from the {held left, right} words and move to LEFT.
REQ-024 Frame delivery: if valid=0, or valid=1 and ready=1 in the same cycle, data_left/data_right SHALL load and valid SHALL be 1 on the next Clk edge.
REQ-025 Frame delivery when valid=1 and ready=0: the frame SHALL be dropped, outputs held, and overrun set to 1.
REQ-026 valid SHALL clear on the Clk edge where valid=1 and ready=1, unless a new frame loads in that same cycle.
REQ-027 Outputs SHALL remain stable while valid=1 and ready=0.
REQ-028 Latency: valid SHALL rise on the 3rd Clk edge after the first Clk edge that samples the frame-completing sclk high.
REQ-029 overrun SHALL clear only on reset.
REQ-030 A ws toggle in SYNC is not a 1->0 boundary and SHALL not cause a commit.

Reset
REQ-031 On Reset_n=0, asynchronously: data_left=0, data_right=0, valid=0, overrun=0.
REQ-032 On Reset_n=0, asynchronously: synchronizers=0, ws_d=0, bit counter=0, shift and holding registers=0, state=SYNC.
REQ-033 A reset mid-word SHALL discard the partial frame; capture resumes only after the next ws 1->0 boundary.

Verification
REQ-034 SIZE=16, ready=1, sclk = Clk/16. Stream one sync frame, then left 16'hA5C3 and right 16'h1234 -> exactly one valid pulse with data_left=A5C3, data_right=1234, overrun=0.
REQ-035 Left word of 8 bits 8'hAB, right word of 16 bits 16'hFFFF -> data_left=16'hAB00, data_right=16'hFFFF.
REQ-036 Left word of 20 bits 20'h12345, right word of 20 bits 20'hFEDCB -> data_left=16'h1234, data_right=16'hFEDC.
REQ-037 ready=0, two complete frames (1111/2222 then 3333/4444) -> valid=1, data 1111/2222 held, overrun=1; with ready=1, valid clears on the next edge.
REQ-038 Start the stream mid-right-word -> that partial frame produces no valid; the next full frame 0F0F/F0F0 is delivered.
REQ-039 Reset_n pulsed low after 5 bits of a left word -> all outputs 0 at once; the next complete frame after a ws 1->0 boundary is delivered correctly.
